// File: rtl/pwr_seq_pkg.sv
// Shared types and constants for the power-sequence write scheduler.
package pwr_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RESP   = 2'd2,
    SETTLE = 2'd3
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/pwr_seq_scheduler_rr_arbiter.sv
// Round-robin picker: lowest requesting index at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  input  logic                       en,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  // Scan from ptr upward; the first hit wins.
  always_comb begin : pick
    logic             found;
    logic [IDX_W-1:0] k;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    k       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = IDX_W'((32'(ptr) + i) % NUM_REQ);
      if (en && !found && req[k]) begin
        gnt[k]  = 1'b1;
        gnt_idx = k;
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwr_seq_scheduler.sv
// Arbitrates power-state writes from several requesters onto one AXI-Lite write master.
module pwr_seq_scheduler
  import pwr_seq_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic [NUM_REQ-1:0]                   done,
  output logic                                 err,
  input  logic [CNT_WIDTH-1:0]                 settle_cycles,
  output logic                                 busy,
  output logic                                 aw_valid,
  input  logic                                 aw_ready,
  output logic [ADDR_WIDTH-1:0]                aw_addr,
  output logic                                 w_valid,
  input  logic                                 w_ready,
  output logic [DATA_WIDTH-1:0]                w_data,
  output logic [DATA_WIDTH/8-1:0]              w_strb,
  input  logic                                 b_valid,
  output logic                                 b_ready,
  input  logic [1:0]                           b_resp
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  state_e                 r_state;
  state_e                 w_next;
  logic [IDX_W-1:0]       r_ptr;
  logic [IDX_W-1:0]       r_gidx;
  logic [IDX_W-1:0]       w_gnt_idx;
  logic [NUM_REQ-1:0]     w_gnt;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [DATA_WIDTH-1:0]  r_data;
  logic                   r_aw_valid;
  logic                   r_w_valid;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic                   w_arb_en;
  logic                   w_aw_fin;
  logic                   w_w_fin;
  logic                   w_tmo;

  assign w_arb_en = (r_state == IDLE) && !rst;
  assign w_aw_fin = !r_aw_valid || aw_ready;
  assign w_w_fin  = !r_w_valid || w_ready;
  assign w_tmo    = (r_cnt >= CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (r_ptr),
    .en      (w_arb_en),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  assign req_ready = w_gnt;
  assign aw_valid  = r_aw_valid;
  assign w_valid   = r_w_valid;
  assign aw_addr   = r_addr;
  assign w_data    = r_data;
  assign w_strb    = '1;
  assign b_ready   = (r_state != ISSUE);
  assign busy      = (r_state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode plus the completion pulse raised on the B beat or timeout.
  always_comb begin
    w_next = r_state;
    done   = '0;
    err    = 1'b0;
    case (r_state)
      IDLE:   if (|w_gnt) w_next = ISSUE;
      ISSUE:  if (w_aw_fin && w_w_fin) w_next = RESP;
      RESP: begin
        if (b_valid) begin
          done[r_gidx] = 1'b1;
          err          = (b_resp != RESP_OKAY);
          w_next       = SETTLE;
        end else if (w_tmo) begin
          done[r_gidx] = 1'b1;
          err          = 1'b1;
          w_next       = SETTLE;
        end
      end
      SETTLE: if (r_cnt == '0) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Capture, channel valids, rotation pointer and the shared timeout/settle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_gidx     <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_aw_valid <= 1'b0;
      r_w_valid  <= 1'b0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_gnt) begin
            r_addr     <= req_addr[w_gnt_idx];
            r_data     <= req_data[w_gnt_idx];
            r_gidx     <= w_gnt_idx;
            r_ptr      <= (w_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + IDX_W'(1);
            r_aw_valid <= 1'b1;
            r_w_valid  <= 1'b1;
          end
        end
        ISSUE: begin
          if (aw_ready) r_aw_valid <= 1'b0;
          if (w_ready)  r_w_valid  <= 1'b0;
          r_cnt <= '0;
        end
        RESP: begin
          if (w_next == SETTLE)  r_cnt <= settle_cycles;
          else if (r_cnt != '1) r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
        SETTLE: begin
          if (r_cnt != '0) r_cnt <= r_cnt - CNT_WIDTH'(1);
        end
        default: r_cnt <= '0;
      endcase
    end
  end

endmodule
